// File: rtl/audio_playback.sv
// Plays back play_len 16-bit samples from an external memory at SAMPLE_RATE, started or aborted
// by a falling edge on the pushbutton. Each sample is fetched and loaded ahead of its output tick.
module audio_playback #(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned SAMPLE_RATE = 48000,
    parameter int unsigned ADDR_W      = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key,
    input  logic [ADDR_W-1:0] play_len,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [15:0]       mem_rd_data,
    output logic [15:0]       audio_out,
    output logic              audio_valid,
    output logic [17:0]       ledr
);

    localparam int unsigned DIV   = CLK_HZ / SAMPLE_RATE;
    localparam int unsigned CNT_W = $clog2(DIV + 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StFetch = 3'd1;
    localparam logic [2:0] StLoad  = 3'd2;
    localparam logic [2:0] StPlay  = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              key_meta_q, key_sync_q, key_prev_q;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
    logic [15:0]       sample_q, sample_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic [15:0]       audio_out_q, audio_out_d;
    logic              audio_valid_q, audio_valid_d;
    logic              done_ok_q, done_ok_d;
    logic              abort_q, abort_d;
    logic              start;
    logic              tick;

    // key_prev_q only exists to detect the 1->0 edge on the already-synchronized level
    assign start = key_prev_q & ~key_sync_q;
    assign tick  = (div_cnt_q == CNT_W'(DIV - 1));

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        idx_d         = idx_q;
        div_cnt_d     = div_cnt_q;
        sample_d      = sample_q;
        mem_addr_d    = mem_addr_q;
        mem_rd_en_d   = 1'b0;
        audio_out_d   = audio_out_q;
        audio_valid_d = 1'b0;
        done_ok_d     = done_ok_q;
        abort_d       = abort_q;
        case (state_q)
            StIdle: begin
                if (start && (play_len != '0)) begin
                    len_d       = play_len;
                    idx_d       = '0;
                    mem_addr_d  = '0;
                    mem_rd_en_d = 1'b1;
                    done_ok_d   = 1'b0;
                    abort_d     = 1'b0;
                    state_d     = StFetch;
                end
            end
            StFetch: begin
                if (start) begin
                    abort_d = 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (start) begin
                    abort_d = 1'b1;
                    state_d = StDone;
                end else begin
                    sample_d  = mem_rd_data;
                    div_cnt_d = '0;
                    state_d   = StPlay;
                end
            end
            StPlay: begin
                if (start) begin
                    abort_d = 1'b1;
                    state_d = StDone;
                end else if (tick) begin
                    div_cnt_d     = '0;
                    audio_out_d   = sample_q;
                    audio_valid_d = 1'b1;
                    idx_d         = idx_q + ADDR_W'(1);
                    if (idx_q == len_q - ADDR_W'(1)) begin
                        done_ok_d = 1'b1;
                        state_d   = StDone;
                    end else begin
                        // read strobe and address are registered, so issue them on FETCH entry
                        mem_addr_d  = idx_q + ADDR_W'(1);
                        mem_rd_en_d = 1'b1;
                        state_d     = StFetch;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                audio_out_d = '0;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            key_meta_q    <= 1'b1;
            key_sync_q    <= 1'b1;
            key_prev_q    <= 1'b1;
            len_q         <= '0;
            idx_q         <= '0;
            div_cnt_q     <= '0;
            sample_q      <= '0;
            mem_addr_q    <= '0;
            mem_rd_en_q   <= 1'b0;
            audio_out_q   <= '0;
            audio_valid_q <= 1'b0;
            done_ok_q     <= 1'b0;
            abort_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_meta_q    <= key;
            key_sync_q    <= key_meta_q;
            key_prev_q    <= key_sync_q;
            len_q         <= len_d;
            idx_q         <= idx_d;
            div_cnt_q     <= div_cnt_d;
            sample_q      <= sample_d;
            mem_addr_q    <= mem_addr_d;
            mem_rd_en_q   <= mem_rd_en_d;
            audio_out_q   <= audio_out_d;
            audio_valid_q <= audio_valid_d;
            done_ok_q     <= done_ok_d;
            abort_q       <= abort_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign audio_out   = audio_out_q;
    assign audio_valid = audio_valid_q;
    assign ledr        = {done_ok_q, abort_q, idx_q[ADDR_W-1 -: 15], state_q != StIdle};

endmodule

// File: doc/audio_playback.md
AUDIO_PLAYBACK -- requirements
Module: audio_playback

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter SAMPLE_RATE, default 48000, playback sample rate in Hz.
REQ-003 SHALL have parameter ADDR_W, default 17, sample memory address width.
REQ-004 SHALL have port clk  input  1  system clock; one clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port key  input  1  play/abort pushbutton, active-low, asynchronous to clk.
REQ-007 SHALL have port play_len  input  ADDR_W  number of samples to play, latched at start.
REQ-008 SHALL have port mem_addr  output  ADDR_W  sample memory read address, registered.
REQ-009 SHALL have port mem_rd_en  output  1  memory read strobe, one-cycle pulse, registered.
REQ-010 SHALL have port mem_rd_data  input  16  read data, valid exactly 1 cycle after mem_rd_en.
REQ-011 SHALL have port audio_out  output  16  current output sample, held between ticks.
REQ-012 SHALL have port audio_valid  output  1  one-cycle pulse each time audio_out updates.
REQ-013 SHALL have port ledr  output  18  status LEDs.

Function
REQ-014 SHALL pass key through a 2-flop synchronizer; a start event is a synchronized 1->0 transition (one-cycle pulse).
REQ-015 SHALL define DIV = CLK_HZ/SAMPLE_RATE (integer truncation; 1041 at defaults); a tick occurs when div_cnt == DIV-1, then div_cnt returns to 0.
REQ-016 SHALL implement states IDLE, FETCH, LOAD, PLAY, DONE.
REQ-017 IDLE: on start event with play_len != 0, latch play_len into len_q, set idx=0, and go to FETCH; a start event with play_len == 0 SHALL be ignored.
REQ-018 FETCH (1 cycle): drive mem_addr=idx and mem_rd_en=1, then go to LOAD.
REQ-019 LOAD (1 cycle): capture mem_rd_data into sample_buf, clear div_cnt, then go to PLAY.
REQ-020 PLAY: div_cnt SHALL count every cycle; on a tick, audio_out<=sample_buf, audio_valid pulses for 1 cycle, and idx increments.
REQ-021 On a tick with idx == len_q-1, go to DONE; otherwise go to FETCH for idx+1.
REQ-022 Sample spacing in PLAY SHALL be exactly DIV+2 cycles (FETCH+LOAD+DIV).
REQ-023 The first audio_valid SHALL occur DIV+2 cycles after the FETCH entry cycle.
REQ-024 A start event in FETCH, LOAD or PLAY SHALL abort: go to DONE with no further audio_valid and no further mem_rd_en.
REQ-025 DONE (1 cycle): set audio_out=0 and go to IDLE; a start event in DONE SHALL be ignored.
REQ-026 mem_rd_en SHALL never be high outside FETCH.
REQ-027 mem_addr SHALL never exceed len_q-1.
REQ-028 len_q SHALL NOT change during playback, even if play_len changes.
REQ-029 ledr[0] SHALL be 1 while the state is not IDLE.
REQ-030 ledr[17] SHALL be set on entering DONE after a complete playback, and cleared on the next accepted start.
REQ-031 ledr[16] SHALL be set on abort and cleared on the next accepted start.
REQ-032 ledr[15:1] SHALL mirror idx[ADDR_W-1:ADDR_W-15] as a progress bar.
REQ-033 On simultaneous tick and start event in PLAY, abort SHALL take priority: no audio_valid pulse.

Reset
REQ-034 On rst_n low, asynchronously: state=IDLE, audio_out=0, audio_valid=0, mem_rd_en=0, mem_addr=0, ledr=0, div_cnt=0, idx=0, len_q=0, synchronizer flops=1.
REQ-035 Reset mid-playback SHALL stop all memory reads immediately; after reset release, the block SHALL stay in IDLE until a new start event.

Verification
REQ-036 CLK_HZ=8, SAMPLE_RATE=1 (DIV=8), play_len=3, memory holding 0x1111/0x2222/0x3333, key pulsed low -> audio_valid exactly 3 times, 10 cycles apart, with audio_out 0x1111/0x2222/0x3333; then ledr[17]=1, audio_out=0.
REQ-037 Same setup with a second key press after the first audio_valid -> no further pulses; ledr[16]=1, ledr[17]=0, state IDLE.
REQ-038 play_len=0 and key pressed -> no mem_rd_en, ledr[0] stays 0.
REQ-039 play_len=1 -> single mem_rd_en at addr 0, single audio_valid, then DONE.
REQ-040 rst_n pulsed low during PLAY with idx=2 -> all outputs 0 within the same cycle; no activity until the next key press.
REQ-041 Key held low for 100 cycles, then released -> exactly one playback is started.
